// File: rtl/addsub_pkg.sv
// Shared encodings and helpers for the chunked add/subtract engine.
package addsub_pkg;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A single-chunk engine still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : addsub_pkg

// File: rtl/chunked_addsub_if.sv
// Request/response bundle between a requester and the chunked add/subtract engine.
interface chunked_addsub_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  mode;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic                  cb_in;
   logic [DATA_WIDTH-1:0] result;
   logic                  cb_out;
   logic                  overflow;
   logic                  busy;
   logic                  done;

   modport master (
      output start, mode, op_a, op_b, cb_in,
      input  result, cb_out, overflow, busy, done
   );

   modport slave (
      input  start, mode, op_a, op_b, cb_in,
      output result, cb_out, overflow, busy, done
   );
endinterface : chunked_addsub_if

// File: rtl/chunk_addsub.sv
// Combinational CHUNK_WIDTH-bit adder/subtractor with carry/borrow in and out.
module chunk_addsub
   import addsub_pkg::*;
#(
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                   i_mode,
   input  logic [CHUNK_WIDTH-1:0] i_a,
   input  logic [CHUNK_WIDTH-1:0] i_b,
   input  logic                   i_cb,
   output logic [CHUNK_WIDTH-1:0] o_res,
   output logic                   o_cb
);
   localparam int SW = CHUNK_WIDTH + 1;

   logic [CHUNK_WIDTH:0] w_sum;
   logic [CHUNK_WIDTH:0] w_diff;

   // One extra bit: carry for add, sign of the (CHUNK_WIDTH+1)-bit difference marks a borrow.
   assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + SW'(i_cb);
   assign w_diff = {1'b0, i_a} - {1'b0, i_b} - SW'(i_cb);

   assign o_res = (i_mode == MODE_ADD) ? w_sum[CHUNK_WIDTH-1:0] : w_diff[CHUNK_WIDTH-1:0];
   assign o_cb  = (i_mode == MODE_ADD) ? w_sum[CHUNK_WIDTH]     : w_diff[CHUNK_WIDTH];

endmodule : chunk_addsub

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: one CHUNK_WIDTH slice per clock, LSB first, carry/borrow kept in a register.
module chunked_addsub
   import addsub_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8
) (
   input logic             clk,
   input logic             reset,
   chunked_addsub_if.slave bus
);
   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
   localparam int CNT_W      = cnt_width(NUM_CHUNKS);

   if ((CHUNK_WIDTH < 1) || (CHUNK_WIDTH > DATA_WIDTH) || (DATA_WIDTH % CHUNK_WIDTH != 0)) begin : g_bad_width
      $fatal(1, "chunked_addsub: DATA_WIDTH must be a positive multiple of CHUNK_WIDTH");
   end

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic                  r_mode;
   logic                  r_cb;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_cb_out;
   logic                  r_overflow;
   logic                  r_busy;
   logic                  r_done;

   logic [CHUNK_WIDTH-1:0] w_chunk;
   logic                   w_cb_next;
   logic                   w_sign_a;
   logic                   w_sign_b;
   logic                   w_sign_r;
   logic                   w_ovf;

   chunk_addsub #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_chunk (
      .i_mode (r_mode),
      .i_a    (r_a[CHUNK_WIDTH-1:0]),
      .i_b    (r_b[CHUNK_WIDTH-1:0]),
      .i_cb   (r_cb),
      .o_res  (w_chunk),
      .o_cb   (w_cb_next)
   );

   // On the last chunk the low operand slices hold the original sign bits.
   assign w_sign_a = r_a[CHUNK_WIDTH-1];
   assign w_sign_b = r_b[CHUNK_WIDTH-1];
   assign w_sign_r = w_chunk[CHUNK_WIDTH-1];
   assign w_ovf    = (r_mode == MODE_ADD) ? ((w_sign_a == w_sign_b) && (w_sign_r != w_sign_a))
                                          : ((w_sign_a != w_sign_b) && (w_sign_r != w_sign_a));

   // NOTE: operand shift registers are reset too, so no stale operand survives an aborted run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_mode     <= MODE_SUB;
         r_cb       <= 1'b0;
         r_result   <= '0;
         r_cb_out   <= 1'b0;
         r_overflow <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.op_a;
                  r_b     <= bus.op_b;
                  r_mode  <= bus.mode;
                  r_cb    <= bus.cb_in;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_result <= (r_result >> CHUNK_WIDTH)
                         | (DATA_WIDTH'(w_chunk) << (DATA_WIDTH - CHUNK_WIDTH));
               r_cb     <= w_cb_next;
               r_a      <= r_a >> CHUNK_WIDTH;
               r_b      <= r_b >> CHUNK_WIDTH;
               if (r_cnt == CNT_W'(NUM_CHUNKS - 1)) begin
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_cb_out   <= w_cb_next;
                  r_overflow <= w_ovf;
                  r_state    <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.result   = r_result;
   assign bus.cb_out   = r_cb_out;
   assign bus.overflow = r_overflow;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule : chunked_addsub

// File: tb/tb_chunked_addsub.sv
// Self-checking bench: three configurations (8/2, 32/8, 16/16) against a whole-word arithmetic model.
module tb_chunked_addsub;

   logic clk;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

   chunked_addsub_if #(.DATA_WIDTH(8))  if8 ();
   chunked_addsub_if #(.DATA_WIDTH(32)) if32 ();
   chunked_addsub_if #(.DATA_WIDTH(16)) if16 ();

   chunked_addsub #(.DATA_WIDTH(8),  .CHUNK_WIDTH(2))  dut8  (.clk(clk), .reset(reset), .bus(if8));
   chunked_addsub #(.DATA_WIDTH(32), .CHUNK_WIDTH(8))  dut32 (.clk(clk), .reset(reset), .bus(if32));
   chunked_addsub #(.DATA_WIDTH(16), .CHUNK_WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: 8/2, instance 1: 32/8, instance 2: 16/16.
   function automatic int width_of(input int id);
      return (id == 0) ? 8 : (id == 1) ? 32 : 16;
   endfunction

   function automatic int chunks_of(input int id);
      return (id == 0) ? 4 : (id == 1) ? 4 : 1;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int id, input logic st, input logic m,
                        input logic [31:0] a, input logic [31:0] b, input logic cin);
      case (id)
         0: begin if8.start  = st; if8.mode  = m; if8.op_a  = a[7:0];  if8.op_b  = b[7:0];  if8.cb_in  = cin; end
         1: begin if32.start = st; if32.mode = m; if32.op_a = a;       if32.op_b = b;       if32.cb_in = cin; end
         default: begin if16.start = st; if16.mode = m; if16.op_a = a[15:0]; if16.op_b = b[15:0]; if16.cb_in = cin; end
      endcase
   endtask

   task automatic sample(input int id, output logic [31:0] res, output logic cb, output logic ov,
                         output logic bs, output logic dn);
      case (id)
         0: begin res = 32'(if8.result);  cb = if8.cb_out;  ov = if8.overflow;  bs = if8.busy;  dn = if8.done;  end
         1: begin res = if32.result;      cb = if32.cb_out; ov = if32.overflow; bs = if32.busy; dn = if32.done; end
         default: begin res = 32'(if16.result); cb = if16.cb_out; ov = if16.overflow; bs = if16.busy; dn = if16.done; end
      endcase
   endtask

   // Whole-word reference: plain arithmetic on the full operands, no chunking.
   task automatic ref_model(input int w, input logic m, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, output logic [31:0] res, output logic cb, output logic ov);
      longint unsigned mask, ua, ub, full;
      logic sa, sb, sr;
      mask = (64'd1 << w) - 1;
      ua   = 64'(a) & mask;
      ub   = 64'(b) & mask;
      if (m) begin
         full = ua + ub + 64'(cin);
         cb   = ((full >> w) & 1) != 0;
      end else begin
         full = ua - ub - 64'(cin);
         cb   = ua < (ub + 64'(cin));
      end
      res = 32'(full & mask);
      sa  = ((ua >> (w - 1)) & 1) != 0;
      sb  = ((ub >> (w - 1)) & 1) != 0;
      sr  = ((64'(res) >> (w - 1)) & 1) != 0;
      ov  = m ? ((sa == sb) && (sr != sa)) : ((sa != sb) && (sr != sa));
   endtask

   // Call at a negedge: presents start for one rising edge, returns at the following negedge.
   task automatic launch(input int id, input logic m, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input string tag);
      logic [31:0] r;
      logic cb, ov, bs, dn;
      drive(id, 1'b1, m, a, b, cin);
      @(negedge clk);
      drive(id, 1'b0, 1'b0, '0, '0, 1'b0);
      sample(id, r, cb, ov, bs, dn);
      check({tag, "_busy_rise"}, bs, 1'b1);
      check({tag, "_no_early_done"}, dn, 1'b0);
   endtask

   // Waits (bounded) for done; returns at the negedge where done is first seen.
   task automatic await_done(input int id, input int exp_cyc, input logic [31:0] er,
                             input logic ecb, input logic eov, input string tag);
      logic [31:0] r;
      logic cb, ov, bs, dn;
      int cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         sample(id, r, cb, ov, bs, dn);
         if (!dn && cyc < exp_cyc) check({tag, "_busy_hold"}, bs, 1'b1);
      end while (!dn && cyc < 40);
      check({tag, "_latency"}, cyc, exp_cyc);
      check({tag, "_busy_fall"}, bs, 1'b0);
      check({tag, "_result"}, r, er);
      check({tag, "_cb_out"}, cb, ecb);
      check({tag, "_overflow"}, ov, eov);
   endtask

   task automatic op_exp(input int id, input logic m, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] er, input logic ecb, input logic eov,
                         input string tag);
      logic [31:0] r;
      logic cb, ov, bs, dn;
      launch(id, m, a, b, cin, tag);
      await_done(id, chunks_of(id), er, ecb, eov, tag);
      @(negedge clk);
      sample(id, r, cb, ov, bs, dn);
      check({tag, "_done_pulse"}, dn, 1'b0);
      check({tag, "_result_hold"}, r, er);
   endtask

   task automatic op_rand(input int id, input string tag);
      logic [31:0] a, b, er;
      logic m, cin, ecb, eov;
      a   = $urandom;
      b   = $urandom;
      m   = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      ref_model(width_of(id), m, a, b, cin, er, ecb, eov);
      op_exp(id, m, a, b, cin, er, ecb, eov, tag);
   endtask

   task automatic check_zero(input int id, input string tag);
      logic [31:0] r;
      logic cb, ov, bs, dn;
      sample(id, r, cb, ov, bs, dn);
      check({tag, "_result"}, r, 32'h0);
      check({tag, "_cb_out"}, cb, 1'b0);
      check({tag, "_overflow"}, ov, 1'b0);
      check({tag, "_busy"}, bs, 1'b0);
      check({tag, "_done"}, dn, 1'b0);
   endtask

   initial begin
      logic [31:0] r, er;
      logic cb, ov, bs, dn, ecb, eov;

      reset = 1'b1;
      for (int id = 0; id < 3; id++) drive(id, 1'b0, 1'b0, '0, '0, 1'b0);
      #3;
      for (int id = 0; id < 3; id++) check_zero(id, "reset_state");
      @(negedge clk);
      reset = 1'b0;

      // 8-bit, 2-bit chunks.
      op_exp(0, 1'b0, 32'h5A, 32'h3C, 1'b0, 32'h1E, 1'b0, 1'b0, "sub_5a_3c");
      op_exp(0, 1'b0, 32'h00, 32'h01, 1'b0, 32'hFF, 1'b1, 1'b0, "sub_00_01");
      op_exp(0, 1'b0, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b0, 1'b1, "sub_80_01");
      op_exp(0, 1'b1, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, "add_ff_01");
      op_exp(0, 1'b1, 32'h7F, 32'h00, 1'b1, 32'h80, 1'b0, 1'b1, "add_7f_00_c1");

      // 16-bit, single chunk.
      op_exp(2, 1'b0, 32'h0005, 32'h0003, 1'b1, 32'h0001, 1'b0, 1'b0, "sub16_single");

      // 32-bit: start while busy is ignored, then a start in the done cycle is accepted.
      launch(1, 1'b0, 32'h12345678, 32'h11111111, 1'b0, "busy_ign");
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
      sample(1, r, cb, ov, bs, dn);
      check("busy_ign_still_busy", bs, 1'b1);
      await_done(1, 2, 32'h01234567, 1'b0, 1'b0, "busy_ign");
      launch(1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, "b2b");
      await_done(1, 4, 32'h00000000, 1'b1, 1'b0, "b2b");
      @(negedge clk);

      // Asynchronous reset in the middle of a run.
      launch(1, 1'b1, 32'h80000000, 32'h80000000, 1'b0, "pre_rst");
      await_done(1, 4, 32'h00000000, 1'b1, 1'b1, "pre_rst");
      launch(1, 1'b0, 32'hCAFEBABE, 32'h01020304, 1'b0, "mid_rst");
      @(negedge clk);
      @(negedge clk);
      sample(1, r, cb, ov, bs, dn);
      check("mid_rst_running", bs, 1'b1);
      #2 reset = 1'b1;
      #1 check_zero(1, "async_rst");
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sample(1, r, cb, ov, bs, dn);
         check("no_done_after_rst", dn, 1'b0);
      end
      ref_model(32, 1'b0, 32'hCAFEBABE, 32'h01020304, 1'b0, er, ecb, eov);
      op_exp(1, 1'b0, 32'hCAFEBABE, 32'h01020304, 1'b0, er, ecb, eov, "post_rst");

      // Randomised operations on every configuration.
      for (int i = 0; i < 12; i++) begin
         for (int id = 0; id < 3; id++) op_rand(id, $sformatf("rand%0d_%0d", id, i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_chunked_addsub
